// File: rtl/label_pkg.sv
// Shared class codes, rule layout and power-on threshold rules for the label pipeline.
package label_pkg;

   localparam int unsigned CLS_W       = 3;
   localparam int unsigned NUM_CLASSES = 5;
   localparam int unsigned DEF_PIX_W   = 8;

   localparam logic [CLS_W-1:0] CLS_ROAD       = 3'd0;
   localparam logic [CLS_W-1:0] CLS_WALK_ROAD  = 3'd1;
   localparam logic [CLS_W-1:0] CLS_BACKGROUND = 3'd2;
   localparam logic [CLS_W-1:0] CLS_CAR        = 3'd3;
   localparam logic [CLS_W-1:0] CLS_HUMAN      = 3'd4;

   // Field order matches the cfg_data write word for 8-bit pixels.
   typedef struct packed {
      logic                 en;
      logic [CLS_W-1:0]     label;
      logic [DEF_PIX_W-1:0] v_lo;
      logic [DEF_PIX_W-1:0] v_hi;
      logic [DEF_PIX_W-1:0] s_lo;
      logic [DEF_PIX_W-1:0] s_hi;
   } rule_t;

   // Bright, weakly saturated pixels are walkway; dark, moderately saturated ones are road.
   localparam rule_t RULE0_DEFAULT = '{en: 1'b1, label: CLS_WALK_ROAD,
                                       v_lo: 8'd179, v_hi: 8'd255, s_lo: 8'd0, s_hi: 8'd51};
   localparam rule_t RULE1_DEFAULT = '{en: 1'b1, label: CLS_ROAD,
                                       v_lo: 8'd0, v_hi: 8'd38, s_lo: 8'd0, s_hi: 8'd77};

endpackage

// File: rtl/label_rule_match.sv
// Combinational single-rule comparator: inclusive S/V window test gated by the rule enable.
module label_rule_match #(
   parameter int unsigned PIX_W = 8
) (
   input  logic             en,
   input  logic [PIX_W-1:0] s_data,
   input  logic [PIX_W-1:0] v_data,
   input  logic [PIX_W-1:0] v_lo,
   input  logic [PIX_W-1:0] v_hi,
   input  logic [PIX_W-1:0] s_lo,
   input  logic [PIX_W-1:0] s_hi,
   output logic             hit_c
);

   // Pixel lies inside both windows of an enabled rule
   always_comb begin
      hit_c = en && (v_data >= v_lo) && (v_data <= v_hi) &&
                    (s_data >= s_lo) && (s_data <= s_hi);
   end

endmodule

// File: rtl/label_gen_pipe.sv
// Two-stage pixel labeller: rule-based HSV classification, 3-tap line majority filter,
// per-frame class statistics.
module label_gen_pipe
   import label_pkg::*;
#(
   parameter int unsigned PIX_W     = 8,
   parameter int unsigned NUM_RULES = 4,
   parameter int unsigned LABEL_W   = 3,
   parameter int unsigned CNT_W     = 19,
   parameter int unsigned FILTER_EN = 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic                             in_sol,
   input  logic                             in_eof,
   input  logic [PIX_W-1:0]                 s_data,
   input  logic [PIX_W-1:0]                 v_data,
   input  logic [1:0]                       r_g_decision,
   input  logic                             cfg_we,
   input  logic [$clog2(NUM_RULES)-1:0]     cfg_addr,
   input  logic [4*PIX_W+LABEL_W:0]         cfg_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [LABEL_W-1:0]               label_data,
   output logic                             out_sol,
   output logic                             out_eof,
   output logic                             stat_valid,
   output logic [NUM_CLASSES*CNT_W-1:0]     stat_cnt
);

   localparam int unsigned AW = $clog2(NUM_RULES);

   // Rule table
   logic               rule_en    [NUM_RULES];
   logic [LABEL_W-1:0] rule_label [NUM_RULES];
   logic [PIX_W-1:0]   rule_v_lo  [NUM_RULES];
   logic [PIX_W-1:0]   rule_v_hi  [NUM_RULES];
   logic [PIX_W-1:0]   rule_s_lo  [NUM_RULES];
   logic [PIX_W-1:0]   rule_s_hi  [NUM_RULES];
   logic [NUM_RULES-1:0] hit_c;

   // Pipeline state
   logic               adv_c;
   logic [LABEL_W-1:0] raw_c;
   logic               s1_valid;
   logic [LABEL_W-1:0] s1_raw;
   logic               s1_sol;
   logic               s1_eof;
   logic [LABEL_W-1:0] tap1;
   logic [LABEL_W-1:0] tap2;
   logic [LABEL_W-1:0] tap1_c;
   logic [LABEL_W-1:0] tap2_c;
   logic [LABEL_W-1:0] filt_c;

   // Statistics
   logic               hs_c;
   logic [CNT_W-1:0]   cnt     [NUM_CLASSES];
   logic [CNT_W-1:0]   cnt_inc_c [NUM_CLASSES];

   // Rule table: reset defaults and decoded writes; out-of-range addresses match no entry
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_RULES; i++) begin
            if (PIX_W == 8 && i == 0) begin
               rule_en[i]    <= RULE0_DEFAULT.en;
               rule_label[i] <= LABEL_W'(RULE0_DEFAULT.label);
               rule_v_lo[i]  <= PIX_W'(RULE0_DEFAULT.v_lo);
               rule_v_hi[i]  <= PIX_W'(RULE0_DEFAULT.v_hi);
               rule_s_lo[i]  <= PIX_W'(RULE0_DEFAULT.s_lo);
               rule_s_hi[i]  <= PIX_W'(RULE0_DEFAULT.s_hi);
            end else if (PIX_W == 8 && i == 1) begin
               rule_en[i]    <= RULE1_DEFAULT.en;
               rule_label[i] <= LABEL_W'(RULE1_DEFAULT.label);
               rule_v_lo[i]  <= PIX_W'(RULE1_DEFAULT.v_lo);
               rule_v_hi[i]  <= PIX_W'(RULE1_DEFAULT.v_hi);
               rule_s_lo[i]  <= PIX_W'(RULE1_DEFAULT.s_lo);
               rule_s_hi[i]  <= PIX_W'(RULE1_DEFAULT.s_hi);
            end else begin
               rule_en[i]    <= 1'b0;
               rule_label[i] <= '0;
               rule_v_lo[i]  <= '0;
               rule_v_hi[i]  <= '0;
               rule_s_lo[i]  <= '0;
               rule_s_hi[i]  <= '0;
            end
         end
      end else begin
         for (int unsigned i = 0; i < NUM_RULES; i++) begin
            if (cfg_we && cfg_addr == AW'(i)) begin
               rule_en[i]    <= cfg_data[4*PIX_W+LABEL_W];
               rule_label[i] <= cfg_data[4*PIX_W +: LABEL_W];
               rule_v_lo[i]  <= cfg_data[3*PIX_W +: PIX_W];
               rule_v_hi[i]  <= cfg_data[2*PIX_W +: PIX_W];
               rule_s_lo[i]  <= cfg_data[PIX_W +: PIX_W];
               rule_s_hi[i]  <= cfg_data[0 +: PIX_W];
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_RULES; g++) begin : g_rule
      label_rule_match #(.PIX_W(PIX_W)) u_match (
         .en     (rule_en[g]),
         .s_data (s_data),
         .v_data (v_data),
         .v_lo   (rule_v_lo[g]),
         .v_hi   (rule_v_hi[g]),
         .s_lo   (rule_s_lo[g]),
         .s_hi   (rule_s_hi[g]),
         .hit_c  (hit_c[g])
      );
   end

   // Raw class: red/green detector wins, then lowest-index matching rule, else background
   always_comb begin
      raw_c = LABEL_W'(CLS_BACKGROUND);
      for (int i = int'(NUM_RULES) - 1; i >= 0; i--) begin
         if (hit_c[i]) raw_c = rule_label[i];
      end
      if (r_g_decision == 2'd0)      raw_c = LABEL_W'(CLS_CAR);
      else if (r_g_decision == 2'd1) raw_c = LABEL_W'(CLS_HUMAN);
   end

   // Whole pipe moves together whenever the output slot is free or being taken
   always_comb begin
      adv_c    = !out_valid || out_ready;
      in_ready = adv_c;
      hs_c     = out_valid && out_ready;
   end

   // Majority of {raw[n], raw[n-1], raw[n-2]}; history restarts at line start
   always_comb begin
      tap1_c = s1_sol ? s1_raw : tap1;
      tap2_c = s1_sol ? s1_raw : tap2;
      if (FILTER_EN != 0 && tap1_c == tap2_c) filt_c = tap1_c;
      else                                    filt_c = s1_raw;
   end

   // Stage 1 raw class, stage 2 filtered label, history taps shift per consumed beat
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid   <= 1'b0;
         s1_raw     <= '0;
         s1_sol     <= 1'b0;
         s1_eof     <= 1'b0;
         out_valid  <= 1'b0;
         label_data <= '0;
         out_sol    <= 1'b0;
         out_eof    <= 1'b0;
         tap1       <= '0;
         tap2       <= '0;
      end else if (adv_c) begin
         s1_valid   <= in_valid;
         s1_raw     <= raw_c;
         s1_sol     <= in_sol;
         s1_eof     <= in_eof;
         out_valid  <= s1_valid;
         label_data <= filt_c;
         out_sol    <= s1_sol;
         out_eof    <= s1_eof;
         if (s1_valid) begin
            tap1 <= s1_raw;
            tap2 <= tap1_c;
         end
      end
   end

   // Saturating next count for each class given the current output beat
   always_comb begin
      for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
         cnt_inc_c[c] = cnt[c];
         if (label_data == LABEL_W'(c) && cnt[c] != '1) cnt_inc_c[c] = cnt[c] + CNT_W'(1);
      end
   end

   // Per-frame counting; frame end publishes totals and restarts the counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned c = 0; c < NUM_CLASSES; c++) cnt[c] <= '0;
         stat_cnt   <= '0;
         stat_valid <= 1'b0;
      end else begin
         stat_valid <= 1'b0;
         if (hs_c) begin
            if (out_eof) begin
               for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
                  stat_cnt[c*CNT_W +: CNT_W] <= cnt_inc_c[c];
                  cnt[c]                     <= '0;
               end
               stat_valid <= 1'b1;
            end else begin
               for (int unsigned c = 0; c < NUM_CLASSES; c++) cnt[c] <= cnt_inc_c[c];
            end
         end
      end
   end

endmodule

// File: tb/tb_label_gen_pipe.sv
// Directed bench for label_gen_pipe: classification, latency, filter, backpressure,
// frame statistics and rule reprogramming. Three rules so an out-of-range address exists.
module tb_label_gen_pipe;
   import label_pkg::*;

   localparam int unsigned PIX_W     = 8;
   localparam int unsigned NUM_RULES = 3;
   localparam int unsigned LABEL_W   = 3;
   localparam int unsigned CNT_W     = 19;

   logic                         clk = 1'b0;
   logic                         reset;
   logic                         in_valid;
   logic                         in_ready;
   logic                         in_sol;
   logic                         in_eof;
   logic [PIX_W-1:0]             s_data;
   logic [PIX_W-1:0]             v_data;
   logic [1:0]                   r_g_decision;
   logic                         cfg_we;
   logic [1:0]                   cfg_addr;
   logic [4*PIX_W+LABEL_W:0]     cfg_data;
   logic                         out_valid;
   logic                         out_ready;
   logic [LABEL_W-1:0]           label_data;
   logic                         out_sol;
   logic                         out_eof;
   logic                         stat_valid;
   logic [5*CNT_W-1:0]           stat_cnt;

   label_gen_pipe #(
      .PIX_W(PIX_W), .NUM_RULES(NUM_RULES), .LABEL_W(LABEL_W), .CNT_W(CNT_W), .FILTER_EN(1)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_sol(in_sol), .in_eof(in_eof),
      .s_data(s_data), .v_data(v_data), .r_g_decision(r_g_decision),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .label_data(label_data), .out_sol(out_sol), .out_eof(out_eof),
      .stat_valid(stat_valid), .stat_cnt(stat_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Input pattern table indexed by intended class: CAR, HUMAN, WALK_ROAD, ROAD, BACKGROUND
   logic [7:0] ps  [5] = '{8'd40,  8'd40,  8'd40,  8'd70, 8'd100};
   logic [7:0] pv  [5] = '{8'd200, 8'd200, 8'd200, 8'd30, 8'd100};
   logic [1:0] prg [5] = '{2'd0,   2'd1,   2'd2,   2'd2,  2'd2};
   logic [2:0] pexp[5] = '{3'd3,   3'd4,   3'd1,   3'd0,  3'd2};

   // Output beat capture {label, sol, eof} and stat pulse capture
   logic [4:0]         got_q[$];
   int                 sv_pulses = 0;

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) got_q.push_back({label_data, out_sol, out_eof});
      if (!reset && stat_valid) sv_pulses++;
   end

   function automatic logic [CNT_W-1:0] cnt_of(input int c);
      logic [5*CNT_W-1:0] tmp;
      tmp = stat_cnt;
      return tmp[c*CNT_W +: CNT_W];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one pixel and hold it until accepted (bounded)
   task automatic send(input logic [7:0] s, input logic [7:0] v, input logic [1:0] rg,
                       input logic sol, input logic eof);
      int waitc;
      waitc        = 0;
      in_valid     = 1'b1;
      s_data       = s;
      v_data       = v;
      r_g_decision = rg;
      in_sol       = sol;
      in_eof       = eof;
      @(negedge clk);
      while (!in_ready && waitc < 50) begin
         @(negedge clk);
         waitc++;
      end
      if (!in_ready) check("send_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Single isolated pixel on an idle pipe: out_valid must rise exactly two cycles later
   task automatic pix_lat(input string tag, input logic [7:0] s, input logic [7:0] v,
                          input logic [1:0] rg, input logic [2:0] exp);
      in_valid     = 1'b1;
      s_data       = s;
      v_data       = v;
      r_g_decision = rg;
      in_sol       = 1'b1;
      in_eof       = 1'b0;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check({tag, "_v1"}, out_valid, 0);
      @(negedge clk);
      check({tag, "_v2"}, out_valid, 1);
      check(tag, label_data, exp);
      step();
   endtask

   task automatic wait_stat(input string tag);
      int waitc;
      waitc = 0;
      while (!stat_valid && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      check({tag, "_sv"}, stat_valid, 1);
      @(negedge clk);
      check({tag, "_pulse"}, stat_valid, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int sv0;
      reset        = 1'b1;
      in_valid     = 1'b0;
      in_sol       = 1'b0;
      in_eof       = 1'b0;
      s_data       = '0;
      v_data       = '0;
      r_g_decision = 2'd2;
      cfg_we       = 1'b0;
      cfg_addr     = '0;
      cfg_data     = '0;
      out_ready    = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_label", label_data, 0);
      check("rst_flags", {out_sol, out_eof}, 0);
      check("rst_stat_valid", stat_valid, 0);
      check("rst_stat_cnt", stat_cnt, 0);
      check("rst_in_ready", in_ready, 1);
      step();
      reset = 1'b0;
      step();

      // Default rules and detector priority
      pix_lat("walk",  8'd40,  8'd200, 2'd2, 3'd1);
      pix_lat("road",  8'd70,  8'd30,  2'd2, 3'd0);
      pix_lat("bg",    8'd100, 8'd100, 2'd2, 3'd2);
      pix_lat("car",   8'd40,  8'd200, 2'd0, 3'd3);
      pix_lat("human", 8'd40,  8'd200, 2'd1, 3'd4);

      // Inclusive window edges
      pix_lat("b_walk_in",  8'd51, 8'd179, 2'd2, 3'd1);
      pix_lat("b_walk_out", 8'd51, 8'd178, 2'd2, 3'd2);
      pix_lat("b_road_in",  8'd77, 8'd38,  2'd2, 3'd0);
      pix_lat("b_road_out", 8'd78, 8'd38,  2'd2, 3'd2);

      // Filter: ROAD,CAR,ROAD,ROAD smooths to ROAD; CAR at new line start survives
      base = got_q.size();
      send(8'd70, 8'd30,  2'd2, 1'b1, 1'b0);
      send(8'd40, 8'd200, 2'd0, 1'b0, 1'b0);
      send(8'd70, 8'd30,  2'd2, 1'b0, 1'b0);
      send(8'd70, 8'd30,  2'd2, 1'b0, 1'b0);
      send(8'd40, 8'd200, 2'd0, 1'b1, 1'b0);
      repeat (4) step();
      check("flt_count", got_q.size() - base, 5);
      if (got_q.size() - base >= 5) begin
         check("flt0", got_q[base+0], {3'd0, 1'b1, 1'b0});
         check("flt1", got_q[base+1], {3'd0, 1'b0, 1'b0});
         check("flt2", got_q[base+2], {3'd0, 1'b0, 1'b0});
         check("flt3", got_q[base+3], {3'd0, 1'b0, 1'b0});
         check("flt_sol", got_q[base+4], {3'd3, 1'b1, 1'b0});
      end

      // Backpressure: 5-cycle stall mid-stream of 10 pixels
      base = got_q.size();
      fork
         begin
            for (int i = 0; i < 10; i++) send(ps[i%5], pv[i%5], prg[i%5], 1'b1, 1'b0);
         end
         begin
            repeat (3) step();
            out_ready = 1'b0;
            repeat (2) step();
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            repeat (3) step();
            out_ready = 1'b1;
         end
      join
      repeat (6) step();
      check("bp_count", got_q.size() - base, 10);
      if (got_q.size() - base >= 10) begin
         for (int i = 0; i < 10; i++)
            check($sformatf("bp%0d", i), got_q[base+i], {pexp[i%5], 1'b1, 1'b0});
      end

      // Reset mid-frame discards in-flight pixels and partial counts
      sv0 = sv_pulses;
      send(8'd40, 8'd200, 2'd0, 1'b1, 1'b0);
      send(8'd40, 8'd200, 2'd0, 1'b0, 1'b0);
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      repeat (3) step();
      @(negedge clk);
      check("rst_flush_valid", out_valid, 0);
      check("rst_flush_stat", stat_cnt, 0);
      check("rst_no_pulse", sv_pulses - sv0, 0);
      step();

      // Stats frame: outputs CCCC / CCCC / RRCC / RRRR -> 10 CAR, 6 ROAD
      sv0  = sv_pulses;
      base = got_q.size();
      for (int ln = 0; ln < 4; ln++) begin
         for (int px = 0; px < 4; px++) begin
            if (ln < 2 || (ln == 2 && px > 0))
               send(8'd40, 8'd200, 2'd0, px == 0, 1'b0);
            else
               send(8'd70, 8'd30, 2'd2, px == 0, ln == 3 && px == 3);
         end
      end
      wait_stat("st1");
      check("st1_car",   cnt_of(3), 10);
      check("st1_road",  cnt_of(0), 6);
      check("st1_walk",  cnt_of(1), 0);
      check("st1_bg",    cnt_of(2), 0);
      check("st1_human", cnt_of(4), 0);
      check("st1_pulses", sv_pulses - sv0, 1);
      if (got_q.size() - base >= 16) begin
         check("st1_l2a", got_q[base+9],  {3'd0, 1'b0, 1'b0});
         check("st1_l2b", got_q[base+10], {3'd3, 1'b0, 1'b0});
         check("st1_eof", got_q[base+15], {3'd0, 1'b0, 1'b1});
      end else begin
         check("st1_count", got_q.size() - base, 16);
      end
      repeat (5) step();
      check("st1_hold", cnt_of(3), 10);

      // Next frame counts from zero
      send(8'd40, 8'd200, 2'd1, 1'b1, 1'b0);
      send(8'd40, 8'd200, 2'd1, 1'b0, 1'b1);
      wait_stat("st2");
      check("st2_human", cnt_of(4), 2);
      check("st2_car",   cnt_of(3), 0);
      check("st2_road",  cnt_of(0), 0);
      step();

      // Rule reprogramming mid-frame
      pix_lat("cfg_pre", 8'd200, 8'd110, 2'd2, 3'd2);
      cfg_we   = 1'b1;
      cfg_addr = 2'd2;
      cfg_data = {1'b1, 3'd4, 8'd100, 8'd120, 8'd0, 8'd255};
      step();
      cfg_we = 1'b0;
      pix_lat("cfg_new", 8'd200, 8'd110, 2'd2, 3'd4);
      cfg_we   = 1'b1;
      cfg_addr = 2'd3;
      cfg_data = {1'b1, 3'd3, 8'd0, 8'd255, 8'd0, 8'd255};
      step();
      cfg_we = 1'b0;
      pix_lat("cfg_oob",   8'd100, 8'd150, 2'd2, 3'd2);
      pix_lat("cfg_keep0", 8'd40,  8'd200, 2'd2, 3'd1);
      pix_lat("cfg_keep1", 8'd70,  8'd30,  2'd2, 3'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
